q_frag_bank_ctrl: RTL and testbench
===================================

// Module: q_frag_bank_ctrl
// PURPOSE
//  Upstream sequencer for a bank of WIDTH Q_FRAG flip-flops. Accepts load/set/reset commands on a
//  valid/ready port and drives each flop's QDI/CZI/QDS/QEN/QST/QRT pins. It then reads the bank's QZ
//  outputs back, checks them and returns a response. Used by configuration and self-test logic.
// PARAMETERS
//  WIDTH       8  number of Q_FRAG flops driven (1..32)
//  PULSE_CYC   2  cycles QST/QRT held high for SET/RESET (1..15)
//  SETTLE_CYC  1  cycles between bank update and QZ sampling (1..15)
// PORTS
//  QCK        in   1      clock; bank shares this clock
//  QRTN       in   1      reset, asynchronous, active-low
//  CMD_VALID  in   1      command valid
//  CMD_READY  out  1      command accepted when VALID&&READY at a QCK rising edge
//  CMD_OP     in   2      00 LOAD_D (QDI path), 01 LOAD_C (CZI path), 10 SET, 11 RESET
//  CMD_DATA   in   WIDTH  load data (ignored for SET/RESET)
//  CMD_MASK   in   WIDTH  per-flop select; unselected flops are never touched
//  QDI        out  WIDTH  to bank QDI
//  CZI        out  WIDTH  to bank CZI
//  QDS        out  1      to bank QDS (1 selects QDI)
//  QEN        out  WIDTH  to bank QEN
//  QST        out  WIDTH  to bank QST
//  QRT        out  WIDTH  to bank QRT
//  QZ         in   WIDTH  readback from bank
//  RSP_VALID  out  1      response valid, held until RSP_READY
//  RSP_READY  in   1      response consumed
//  RSP_DATA   out  WIDTH  sampled QZ
//  RSP_ERR    out  1      1 = a masked bit differs from its expected value
//  ERR_CNT    out  8      saturating count of responses with RSP_ERR=1
// BEHAVIOUR
//  - Outputs: all outputs are registered.
//  - Reset: while QRTN=0, every output is 0 (including QDS and CMD_READY) and the FSM is in IDLE.
//  - Reset mid-command: QST/QRT/QEN drop asynchronously, the command is lost, no response is issued
//    and ERR_CNT clears.
//  - FSM states: IDLE, DRIVE, PULSE, SETTLE, RESP. CMD_READY=1 only in IDLE; commands are not pipelined.
//  - Accept edge a: CMD_OP, CMD_DATA and CMD_MASK are captured. Expected value:
//    LOAD_* -> CMD_DATA, SET -> all 1, RESET -> all 0.
//  - LOAD_D: DRIVE for one cycle after edge a. QDS=1, QDI=DATA, QEN=MASK; the bank captures at edge a+1.
//  - LOAD_C: as LOAD_D, but with QDS=0, CZI=DATA and QDI=0.
//  - SET: PULSE for PULSE_CYC cycles after edge a with QST=MASK, QEN=0, QRT=0.
//  - RESET: as SET, but drives QRT=MASK and QST=0.
//  - QST and QRT are never high together on any bit; QEN is never high during PULSE.
//  - After DRIVE or PULSE, the FSM spends SETTLE_CYC cycles in SETTLE with all drive outputs at 0.
//    QDS holds its last value; QDI/CZI return to 0.
//  - Response timing: on the last SETTLE edge, RSP_DATA<=QZ, RSP_ERR<=|((QZ^expected)&MASK) and
//    RSP_VALID<=1 (state RESP).
//    - LOAD: RSP_VALID rises at edge a+1+SETTLE_CYC.
//    - SET/RESET: RSP_VALID rises at edge a+PULSE_CYC+SETTLE_CYC.
//  - ERR_CNT increments by 1 on that same edge when RSP_ERR=1 and saturates at 255.
//  - RESP: RSP_VALID, RSP_DATA and RSP_ERR stay stable until RSP_VALID&&RSP_READY. On that edge the
//    FSM goes to IDLE and CMD_READY=1 the next cycle. RSP_READY outside RESP is ignored.
//  - CMD_MASK=0: the full sequence still runs with no pins asserted; RSP_ERR=0.
//  - CMD_VALID may be asserted in any state; it is only sampled in IDLE.
//  - Counters are sized for the maximum parameter values; no wrap-around occurs inside a command.
// TESTING
//  1. Reset with QRTN=0 for 3 cycles -> all outputs 0. After release, CMD_READY=1 after the next QCK edge.
//  2. LOAD_D DATA=8'hA5 MASK=8'hFF with a Q_FRAG bank model, RSP_READY=1
//     -> QEN=FF and QDS=1 for exactly 1 cycle; RSP_VALID at edge a+2; RSP_DATA=A5; RSP_ERR=0.
//  3. SET MASK=8'h0F from all-zero bank -> QST=0F for 2 cycles with QRT=0 and QEN=0;
//     RSP at edge a+3; RSP_DATA=0F; RSP_ERR=0.
//  4. LOAD_C DATA=8'h3C with bank bit 2 stuck-at-0
//     -> CZI=3C, QDS=0; RSP_DATA=38, RSP_ERR=1, ERR_CNT=1. Repeat 300 times -> ERR_CNT=255.
//  5. RSP_READY held low for 5 cycles -> RSP_VALID/RSP_DATA stable; CMD_READY=0 throughout;
//     a new CMD_VALID is not accepted until the cycle after the response handshake.
//  6. RESET command, assert QRTN=0 during the second PULSE cycle
//     -> QRT drops to 0 asynchronously; no RSP_VALID; after release, IDLE and ERR_CNT=0.

Source files
------------

// File: rtl/q_frag_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// q_frag_bank_ctrl_if
//   Bundles the command port, the response port and the Q_FRAG bank pins
//   of q_frag_bank_ctrl. QCK/QRTN are kept outside as plain ports.
//   slave  : view of the controller (q_frag_bank_ctrl)
//   master : view of the environment (command source + bank + response sink)
//   Command : CMD_VALID, CMD_READY, CMD_OP[1:0], CMD_DATA, CMD_MASK
//   Bank    : QDI, CZI, QDS, QEN, QST, QRT (to bank), QZ (from bank)
//   Response: RSP_VALID, RSP_READY, RSP_DATA, RSP_ERR, ERR_CNT[7:0]
// ---------------------------------------------------------------------------
interface q_frag_bank_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [WIDTH-1:0] CMD_DATA;
  logic [WIDTH-1:0] CMD_MASK;

  logic [WIDTH-1:0] QDI;
  logic [WIDTH-1:0] CZI;
  logic             QDS;
  logic [WIDTH-1:0] QEN;
  logic [WIDTH-1:0] QST;
  logic [WIDTH-1:0] QRT;
  logic [WIDTH-1:0] QZ;

  logic             RSP_VALID;
  logic             RSP_READY;
  logic [WIDTH-1:0] RSP_DATA;
  logic             RSP_ERR;
  logic [7:0]       ERR_CNT;

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DATA, CMD_MASK, QZ, RSP_READY,
    output CMD_READY, QDI, CZI, QDS, QEN, QST, QRT,
           RSP_VALID, RSP_DATA, RSP_ERR, ERR_CNT
  );

  modport master (
    output CMD_VALID, CMD_OP, CMD_DATA, CMD_MASK, QZ, RSP_READY,
    input  CMD_READY, QDI, CZI, QDS, QEN, QST, QRT,
           RSP_VALID, RSP_DATA, RSP_ERR, ERR_CNT
  );
endinterface

// File: rtl/q_frag_bank_ctrl.sv
// ---------------------------------------------------------------------------
// q_frag_bank_ctrl
//   Sequencer for a bank of WIDTH Q_FRAG flops sharing QCK. Takes one
//   LOAD_D / LOAD_C / SET / RESET command at a time, drives the bank pins,
//   waits SETTLE_CYC cycles, samples QZ and returns it with an error flag
//   (masked bits that differ from the expected value). ERR_CNT counts
//   erroneous responses, saturating at 255.
// Ports
//   QCK   : clock (shared with the bank)
//   QRTN  : asynchronous active-low reset; clears every output
//   bus   : q_frag_bank_ctrl_if.slave (command, bank pins, response)
// Parameters
//   WIDTH      : flops in the bank (1..32), must match the interface WIDTH
//   PULSE_CYC  : cycles QST/QRT are held for SET/RESET (1..15)
//   SETTLE_CYC : cycles between bank update and QZ sampling (1..15)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module q_frag_bank_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic               QCK,
  input  logic               QRTN,
  q_frag_bank_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    PULSE  = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD_D = 2'b00;
  localparam logic [1:0] OP_LOAD_C = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_RESET  = 2'b11;

  // Counters hold "cycles remaining minus one", so they cover 1..15.
  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] exp_q, exp_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0] qdi_q, qdi_d;
  logic [WIDTH-1:0] czi_q, czi_d;
  logic             qds_q, qds_d;
  logic [WIDTH-1:0] qen_q, qen_d;
  logic [WIDTH-1:0] qst_q, qst_d;
  logic [WIDTH-1:0] qrt_q, qrt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             sample_err;

  assign sample_err = |((bus.QZ ^ exp_q) & mask_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    mask_d      = mask_q;
    exp_d       = exp_q;
    cmd_ready_d = 1'b0;
    // Drive pins are only high in the one state that needs them, so they
    // default to 0 every cycle. QDS is the exception: it keeps its value.
    qdi_d       = '0;
    czi_d       = '0;
    qds_d       = qds_q;
    qen_d       = '0;
    qst_d       = '0;
    qrt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        // Handshake uses the registered READY, so the first edge after
        // reset release never accepts.
        if (bus.CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = bus.CMD_OP;
          mask_d      = bus.CMD_MASK;
          unique case (bus.CMD_OP)
            OP_LOAD_D: begin
              exp_d   = bus.CMD_DATA;
              state_d = DRIVE;
              qds_d   = 1'b1;
              qdi_d   = bus.CMD_DATA;
              qen_d   = bus.CMD_MASK;
            end
            OP_LOAD_C: begin
              exp_d   = bus.CMD_DATA;
              state_d = DRIVE;
              qds_d   = 1'b0;
              czi_d   = bus.CMD_DATA;
              qen_d   = bus.CMD_MASK;
            end
            OP_SET: begin
              exp_d   = '1;
              state_d = PULSE;
              cnt_d   = PULSE_LAST;
              qst_d   = bus.CMD_MASK;
            end
            default: begin  // OP_RESET
              exp_d   = '0;
              state_d = PULSE;
              cnt_d   = PULSE_LAST;
              qrt_d   = bus.CMD_MASK;
            end
          endcase
        end
      end

      DRIVE: begin
        // Bank captures on this edge; pins return to 0 with it.
        state_d = SETTLE;
        cnt_d   = SETTLE_LAST;
      end

      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
          // Only one of QST/QRT is ever selected by the stored opcode.
          qst_d = (op_q == OP_SET)   ? mask_q : '0;
          qrt_d = (op_q == OP_RESET) ? mask_q : '0;
        end
      end

      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.QZ;
          rsp_err_d   = sample_err;
          if (sample_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        if (bus.RSP_READY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      mask_q      <= '0;
      exp_q       <= '0;
      cmd_ready_q <= 1'b0;
      qdi_q       <= '0;
      czi_q       <= '0;
      qds_q       <= 1'b0;
      qen_q       <= '0;
      qst_q       <= '0;
      qrt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      exp_q       <= exp_d;
      cmd_ready_q <= cmd_ready_d;
      qdi_q       <= qdi_d;
      czi_q       <= czi_d;
      qds_q       <= qds_d;
      qen_q       <= qen_d;
      qst_q       <= qst_d;
      qrt_q       <= qrt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.CMD_READY = cmd_ready_q;
  assign bus.QDI       = qdi_q;
  assign bus.CZI       = czi_q;
  assign bus.QDS       = qds_q;
  assign bus.QEN       = qen_q;
  assign bus.QST       = qst_q;
  assign bus.QRT       = qrt_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_q_frag_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_q_frag_bank_ctrl
//   Directed bench for q_frag_bank_ctrl (WIDTH=8, PULSE_CYC=2, SETTLE_CYC=1)
//   with a behavioural Q_FRAG bank that can hold chosen bits stuck at 0.
// ---------------------------------------------------------------------------
module tb_q_frag_bank_ctrl;

  localparam int WIDTH      = 8;
  localparam int PULSE_CYC  = 2;
  localparam int SETTLE_CYC = 1;

  localparam logic [1:0] OP_LOAD_D = 2'b00;
  localparam logic [1:0] OP_LOAD_C = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_RESET  = 2'b11;

  logic clk;
  logic rst_n;

  q_frag_bank_ctrl_if #(.WIDTH(WIDTH)) bus ();

  q_frag_bank_ctrl #(
    .WIDTH      (WIDTH),
    .PULSE_CYC  (PULSE_CYC),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .QCK  (clk),
    .QRTN (rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q_FRAG bank model: QRT wins over QST, QST over QEN load.
  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] stuck0;

  initial bank = '0;
  always @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.QRT[i])      bank[i] <= 1'b0;
      else if (bus.QST[i]) bank[i] <= 1'b1;
      else if (bus.QEN[i]) bank[i] <= bus.QDS ? bus.QDI[i] : bus.CZI[i];
    end
  end
  assign bus.QZ = bank & ~stuck0;

  int tests;
  int fails;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Checks the bank pins during an active drive/pulse cycle.
  task automatic chk_drive(input logic [1:0] op, input logic [7:0] data, input logic [7:0] mask);
    case (op)
      OP_LOAD_D: begin
        chk("ld_d_qen", bus.QEN, mask);
        chk("ld_d_qds", bus.QDS, 1);
        chk("ld_d_qdi", bus.QDI, data);
        chk("ld_d_czi", bus.CZI, 0);
        chk("ld_d_qstqrt", bus.QST | bus.QRT, 0);
      end
      OP_LOAD_C: begin
        chk("ld_c_qen", bus.QEN, mask);
        chk("ld_c_qds", bus.QDS, 0);
        chk("ld_c_czi", bus.CZI, data);
        chk("ld_c_qdi", bus.QDI, 0);
        chk("ld_c_qstqrt", bus.QST | bus.QRT, 0);
      end
      OP_SET: begin
        chk("set_qst", bus.QST, mask);
        chk("set_qrt", bus.QRT, 0);
        chk("set_qen", bus.QEN, 0);
      end
      default: begin
        chk("rst_qrt", bus.QRT, mask);
        chk("rst_qst", bus.QST, 0);
        chk("rst_qen", bus.QEN, 0);
      end
    endcase
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.CMD_READY && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.CMD_READY) chk("cmd_ready_timeout", 0, 1);
  endtask

  // Issues one command (RSP_READY assumed 1) and checks pins, latency,
  // response and ERR_CNT.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] mask,
                         input logic [7:0] exp_rsp, input logic exp_err, input logic [7:0] exp_cnt);
    int drive_len;
    int exp_lat;
    bit got;
    wait_ready();
    bus.CMD_OP    = op;
    bus.CMD_DATA  = data;
    bus.CMD_MASK  = mask;
    bus.CMD_VALID = 1'b1;
    @(posedge clk);            // edge a
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    chk("accept_ready_low", bus.CMD_READY, 0);
    chk_drive(op, data, mask);
    drive_len = (op[1] == 1'b0) ? 1 : PULSE_CYC;
    exp_lat   = drive_len + SETTLE_CYC;
    got = 1'b0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      if (k < drive_len) chk_drive(op, data, mask);
      if (k == drive_len) begin
        chk("settle_pins", bus.QEN | bus.QST | bus.QRT | bus.QDI | bus.CZI, 0);
      end
      if (bus.RSP_VALID) begin
        got = 1'b1;
        chk("rsp_latency", k, exp_lat);
        chk("rsp_data", bus.RSP_DATA, exp_rsp);
        chk("rsp_err", bus.RSP_ERR, exp_err);
        chk("err_cnt", bus.ERR_CNT, exp_cnt);
      end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    @(negedge clk);
    chk("post_hs_rsp_valid", bus.RSP_VALID, 0);
    chk("post_hs_cmd_ready", bus.CMD_READY, 1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] stuck;
    logic [7:0] exp_rsp;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int got_cnt;
    logic [7:0] exp_cnt;
    bit got;

    tests = 0;
    fails = 0;

    //            op         data   mask   stuck  rsp    err   cnt
    vecs[0] = '{OP_LOAD_D, 8'hA5, 8'hFF, 8'h00, 8'hA5, 1'b0, 8'd0};
    vecs[1] = '{OP_RESET,  8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'd0};
    vecs[2] = '{OP_SET,    8'hFF, 8'h0F, 8'h00, 8'h0F, 1'b0, 8'd0};
    vecs[3] = '{OP_LOAD_C, 8'h3C, 8'hF0, 8'h00, 8'h3F, 1'b0, 8'd0};
    vecs[4] = '{OP_LOAD_D, 8'h00, 8'h00, 8'h00, 8'h3F, 1'b0, 8'd0};
    vecs[5] = '{OP_RESET,  8'h00, 8'h30, 8'h00, 8'h0F, 1'b0, 8'd0};
    vecs[6] = '{OP_LOAD_C, 8'h3C, 8'hFF, 8'h04, 8'h38, 1'b1, 8'd1};
    vecs[7] = '{OP_SET,    8'h00, 8'hFF, 8'h04, 8'hFB, 1'b1, 8'd2};
    vecs[8] = '{OP_RESET,  8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 8'd2};

    // Reset: all outputs 0 while QRTN low.
    rst_n         = 1'b0;
    stuck0        = '0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = '0;
    bus.CMD_DATA  = '0;
    bus.CMD_MASK  = '0;
    bus.RSP_READY = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", bus.CMD_READY, 0);
    chk("reset_pins", bus.QDI | bus.CZI | bus.QEN | bus.QST | bus.QRT, 0);
    chk("reset_qds", bus.QDS, 0);
    chk("reset_rsp", {bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA}, 0);
    chk("reset_err_cnt", bus.ERR_CNT, 0);
    rst_n = 1'b1;
    #1;
    chk("release_ready_low", bus.CMD_READY, 0);
    @(negedge clk);
    chk("release_ready_high", bus.CMD_READY, 1);

    // Table-driven commands.
    foreach (vecs[i]) begin
      stuck0 = vecs[i].stuck;
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].mask,
              vecs[i].exp_rsp, vecs[i].exp_err, vecs[i].exp_cnt);
      $display("[TB] vec %0d op=%0d data=%02h mask=%02h -> rsp=%02h err=%0d cnt=%0d",
               i, vecs[i].op, vecs[i].data, vecs[i].mask, bus.RSP_DATA, bus.RSP_ERR, bus.ERR_CNT);
    end

    // ERR_CNT saturation: 300 failing LOAD_C commands.
    stuck0  = 8'h04;
    exp_cnt = 8'd2;
    for (int r = 0; r < 300; r++) begin
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      run_cmd(OP_LOAD_C, 8'h3C, 8'hFF, 8'h38, 1'b1, exp_cnt);
    end
    chk("err_cnt_saturated", bus.ERR_CNT, 255);
    $display("[TB] saturation loop done: err_cnt=%0d", bus.ERR_CNT);

    // Back-pressure: response held, new command waits for the handshake.
    stuck0        = '0;
    bus.RSP_READY = 1'b0;
    wait_ready();
    bus.CMD_OP    = OP_LOAD_D;
    bus.CMD_DATA  = 8'h5A;
    bus.CMD_MASK  = 8'hFF;
    bus.CMD_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.RSP_VALID) got = 1'b1;
    end
    if (!got) chk("bp_rsp_timeout", 0, 1);
    bus.CMD_OP    = OP_SET;
    bus.CMD_DATA  = 8'h00;
    bus.CMD_MASK  = 8'h81;
    bus.CMD_VALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.RSP_VALID, 1);
      chk("bp_rsp_data", bus.RSP_DATA, 8'h5A);
      chk("bp_cmd_ready", bus.CMD_READY, 0);
      chk("bp_no_accept", bus.QST, 0);
    end
    bus.RSP_READY = 1'b1;
    @(negedge clk);
    chk("bp_hs_rsp_valid", bus.RSP_VALID, 0);
    chk("bp_hs_cmd_ready", bus.CMD_READY, 1);
    chk("bp_hs_not_yet", bus.QST, 0);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    chk("bp_accept_qst", bus.QST, 8'h81);
    chk("bp_accept_ready", bus.CMD_READY, 0);
    got = 1'b0;
    got_cnt = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got_cnt++;
      if (bus.RSP_VALID) begin
        got = 1'b1;
        chk("bp_set_rsp", bus.RSP_DATA, 8'hDB);
        chk("bp_set_latency", got_cnt, PULSE_CYC + SETTLE_CYC);
      end
    end
    if (!got) chk("bp_set_timeout", 0, 1);
    @(negedge clk);
    $display("[TB] backpressure sequence done");

    // Reset during the second PULSE cycle of a RESET command.
    chk("pre_abort_err_cnt", bus.ERR_CNT, 255);
    wait_ready();
    bus.CMD_OP    = OP_RESET;
    bus.CMD_DATA  = 8'h00;
    bus.CMD_MASK  = 8'hFF;
    bus.CMD_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    chk("abort_pulse1_qrt", bus.QRT, 8'hFF);
    @(posedge clk);
    #2;
    chk("abort_pulse2_qrt", bus.QRT, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("abort_qrt_async", bus.QRT, 0);
    chk("abort_qen_qst", bus.QEN | bus.QST, 0);
    chk("abort_err_cnt", bus.ERR_CNT, 0);
    chk("abort_cmd_ready", bus.CMD_READY, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", bus.RSP_VALID, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", bus.CMD_READY, 1);
    chk("abort_idle_rsp", bus.RSP_VALID, 0);
    chk("abort_idle_err_cnt", bus.ERR_CNT, 0);
    @(negedge clk);
    chk("abort_no_late_rsp", bus.RSP_VALID, 0);
    $display("[TB] reset-abort sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
